// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and constants for the AXI4-Lite command master
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] WSTRB_ALL   = 4'hF;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// rtl/axi_lite_timeout_ctr.sv - saturating per-transaction timeout counter
module axi_lite_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    // Count waiting cycles; hold at the last value so a late handshake cannot wrap it
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite initiator driven by a cmd/rsp port pair
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    state_t state_q, state_d;

    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          bready_q, bready_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                    rsp_resp_q, rsp_resp_d;
    logic                          rsp_timeout_q, rsp_timeout_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;
    logic abort;
    logic aw_fire;
    logic w_fire;

    axi_lite_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    assign tmr_enable = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                        (state_q == RD_REQ) || (state_q == RD_DATA);
    assign aw_fire    = awvalid_q && M_AXI_AWREADY;
    assign w_fire     = wvalid_q && M_AXI_WREADY;

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        tmr_clear     = 1'b0;
        abort         = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    tmr_clear = 1'b1;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if (aw_fire) awvalid_d = 1'b0;
                if (w_fire)  wvalid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d      = 1'b0;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d      = 1'b0;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_OKAY;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hung slave: drop every valid/ready at once and report SLVERR with a timeout flag
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
            state_d       = RSP;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = WSTRB_ALL;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - self-checking bench for axi_lite_cmd_master
module tb_axi_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [8:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [8:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (9),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          aw_d;
        int          w_d;
        int          b_d;
        int          ar_d;
        int          r_d;
        logic        never_b;
        logic [1:0]  slv_resp;
        logic [31:0] slv_rdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_to;
    } vec_t;

    int passed = 0;
    int total  = 0;

    int          bfm_aw_d = 0, bfm_w_d = 0, bfm_b_d = 0, bfm_ar_d = 0, bfm_r_d = 0;
    logic        bfm_never_b = 1'b0;
    logic [1:0]  bfm_resp = 2'b00;
    logic [31:0] bfm_rdata = 32'h0;

    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
    int          aw_unstable = 0, bready_early = 0;
    logic        aw_prev_v = 1'b0;
    logic [8:0]  aw_prev_addr = '0;
    logic [8:0]  last_awaddr = '0, last_araddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Slave model with per-channel ready/valid delays, plus bus monitors
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (awvalid) begin
                awready = (aw_cnt >= bfm_aw_d);
                if (!awready) aw_cnt++;
                aw_cyc++;
                if (aw_prev_v && (awaddr != aw_prev_addr)) aw_unstable++;
                if (awready) last_awaddr = awaddr;
            end else begin
                awready = 1'b0; aw_cnt = 0;
            end
            aw_prev_v = awvalid; aw_prev_addr = awaddr;
            if (wvalid) begin
                wready = (w_cnt >= bfm_w_d);
                if (!wready) w_cnt++;
                w_cyc++;
                if (wready) begin last_wdata = wdata; last_wstrb = wstrb; end
            end else begin
                wready = 1'b0; w_cnt = 0;
            end
            if (arvalid) begin
                arready = (ar_cnt >= bfm_ar_d);
                if (!arready) ar_cnt++;
                ar_cyc++;
                if (arready) last_araddr = araddr;
            end else begin
                arready = 1'b0; ar_cnt = 0;
            end
            if (bready && !bfm_never_b) begin
                bvalid = (b_cnt >= bfm_b_d);
                if (!bvalid) b_cnt++;
            end else begin
                bvalid = 1'b0; b_cnt = 0;
            end
            bresp = bvalid ? bfm_resp : 2'b00;
            if (rready) begin
                rvalid = (r_cnt >= bfm_r_d);
                if (!rvalid) r_cnt++;
            end else begin
                rvalid = 1'b0; r_cnt = 0;
            end
            rdata = rvalid ? bfm_rdata : 32'h0;
            rresp = rvalid ? bfm_resp : 2'b00;
            if (bready && (awvalid || wvalid)) bready_early++;
        end
    end

    // Present one command; returns in cycle 1 (first negedge after acceptance)
    task automatic issue(input logic wr, input logic [8:0] addr, input logic [31:0] wd, input string tag);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        check({tag, "_cmd_ready_idle"}, {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, aw0, w0, ar0, un0, be0;
        bfm_aw_d = v.aw_d; bfm_w_d = v.w_d; bfm_b_d = v.b_d; bfm_ar_d = v.ar_d; bfm_r_d = v.r_d;
        bfm_never_b = v.never_b; bfm_resp = v.slv_resp; bfm_rdata = v.slv_rdata;
        aw0 = aw_cyc; w0 = w_cyc; ar0 = ar_cyc; un0 = aw_unstable; be0 = bready_early;
        issue(v.wr, v.addr, v.wdata, tag);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_resp"}, {30'b0, rsp_resp}, {30'b0, v.exp_resp});
        check({tag, "_timeout"}, {31'b0, rsp_timeout}, {31'b0, v.exp_to});
        check({tag, "_bready_at_rsp"}, {31'b0, bready}, 32'd0);
        check({tag, "_aw_cycles"}, aw_cyc - aw0, v.wr ? v.aw_d + 1 : 0);
        check({tag, "_w_cycles"}, w_cyc - w0, v.wr ? v.w_d + 1 : 0);
        check({tag, "_ar_cycles"}, ar_cyc - ar0, v.wr ? 0 : v.ar_d + 1);
        if (v.wr) begin
            check({tag, "_awaddr"}, {23'b0, last_awaddr}, {23'b0, v.addr});
            check({tag, "_wdata"}, last_wdata, v.wdata);
            check({tag, "_wstrb"}, {28'b0, last_wstrb}, 32'hF);
            check({tag, "_awaddr_stable"}, aw_unstable - un0, 0);
            check({tag, "_bready_after_aw_w"}, bready_early - be0, 0);
        end else begin
            check({tag, "_araddr"}, {23'b0, last_araddr}, {23'b0, v.addr});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_cmd_ready_after"}, {31'b0, cmd_ready}, 32'd1);
        check({tag, "_rsp_valid_after"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_bready_after"}, {31'b0, bready}, 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rsp_seen;
        //             wr    addr    wdata          aw w  b  ar r  nb    resp   slv_rdata      lat exp_rdata      exp_resp to
        vecs[0] = '{1'b1, 9'h004, 32'h0000_0012, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0,         3,  32'h0,         2'b00, 1'b0};
        vecs[1] = '{1'b0, 9'h008, 32'h0,         0, 0, 0, 0, 2, 1'b0, 2'b00, 32'hDEAD_BEEF, 5,  32'hDEAD_BEEF, 2'b00, 1'b0};
        vecs[2] = '{1'b1, 9'h1FC, 32'hA5A5_5A5A, 3, 0, 1, 0, 0, 1'b0, 2'b10, 32'h0,         7,  32'h0,         2'b10, 1'b0};
        vecs[3] = '{1'b0, 9'h010, 32'h0,         0, 0, 0, 1, 0, 1'b0, 2'b10, 32'h1234_5678, 4,  32'h1234_5678, 2'b10, 1'b0};
        vecs[4] = '{1'b1, 9'h0C0, 32'hFFFF_FFFF, 0, 2, 0, 0, 0, 1'b0, 2'b11, 32'h0,         5,  32'h0,         2'b11, 1'b0};
        vecs[5] = '{1'b1, 9'h030, 32'h0000_00AB, 0, 0, 14, 0, 0, 1'b0, 2'b00, 32'h0,        17, 32'h0,         2'b00, 1'b0};
        vecs[6] = '{1'b1, 9'h034, 32'h0000_00CD, 0, 0, 15, 0, 0, 1'b0, 2'b00, 32'h0,        17, 32'h0,         2'b10, 1'b1};
        vecs[7] = '{1'b1, 9'h020, 32'h0000_0055, 0, 0, 0, 0, 0, 1'b1, 2'b00, 32'h0,         17, 32'h0,         2'b10, 1'b1};
        vecs[8] = '{1'b0, 9'h000, 32'h0,         0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0BAD_F00D, 3,  32'h0BAD_F00D, 2'b00, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("reset_valids", {26'b0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
        check("reset_rsp", {rsp_rdata[28:0], rsp_resp, rsp_timeout}, 32'd0);
        check("reset_buses", {14'b0, awaddr, araddr}, 32'd0);
        check("reset_wdata", wdata, 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Response back-pressure: rsp_* frozen and no new command accepted
        bfm_ar_d = 0; bfm_r_d = 0; bfm_never_b = 1'b0; bfm_resp = 2'b01; bfm_rdata = 32'hCAFE_F00D;
        issue(1'b0, 9'h00C, 32'h0, "bp");
        wait_rsp(lat);
        check("bp_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_valid", k), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("bp_hold%0d_rdata", k), rsp_rdata, 32'hCAFE_F00D);
            check($sformatf("bp_hold%0d_resp", k), {29'b0, rsp_timeout, rsp_resp}, 32'd1);
            check($sformatf("bp_hold%0d_cmd_ready", k), {31'b0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);

        // Reset while waiting in RD_DATA discards the read
        bfm_resp = 2'b00; bfm_rdata = 32'h7777_7777; bfm_r_d = 10;
        issue(1'b0, 9'h014, 32'h0, "rst");
        @(negedge clk);
        check("rst_in_rd_data", {30'b0, arvalid, rready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valids", {29'b0, arvalid, rready, rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rsp_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        check("rst_no_response", rsp_seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
